// File: rtl/audio_out.sv
// 1-bit sound net to 16-bit PCM: one-pole low-pass IIR at the system clock,
// decimated to the audio rate by a fractional-N phase accumulator.
module audio_out #(
  parameter int unsigned CLK_HZ     = 7_159_000,
  parameter int unsigned SAMPLE_HZ  = 48_000,
  parameter logic [15:0] AMPLITUDE  = 16'd16383,
  parameter int unsigned SHIFT      = 6,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input  logic        clk7_159,
  input  logic        reset,
  input  logic        sound_in,
  input  logic        mute,
  input  logic [1:0]  volume,
  output logic [15:0] sample,
  output logic        sample_strobe
);

  localparam int unsigned AccW = 16 + SHIFT;

  logic [15:0]     x;
  logic [15:0]     y;
  logic [AccW-1:0] acc_q, acc_d;
  logic [23:0]     phase_q, phase_d;
  logic [24:0]     nxt;
  logic            strobe_d, strobe_q;
  logic [15:0]     sample_q;

  always_comb begin
    x = 16'd0;
    if (!mute && (sound_in != IDLE_LEVEL)) begin
      x = AMPLITUDE >> volume;
    end
  end

  // acc stays below (AMPLITUDE << SHIFT) + 2^SHIFT, so AccW bits never overflow.
  always_comb begin
    acc_d = acc_q + AccW'(x) - (acc_q >> SHIFT);
    y     = acc_q[SHIFT +: 16];
  end

  always_comb begin
    nxt      = {1'b0, phase_q} + 25'(SAMPLE_HZ);
    strobe_d = (nxt >= 25'(CLK_HZ));
    phase_d  = strobe_d ? 24'(nxt - 25'(CLK_HZ)) : nxt[23:0];
  end

  always_ff @(posedge clk7_159) begin
    if (reset) begin
      acc_q    <= '0;
      phase_q  <= '0;
      sample_q <= '0;
      strobe_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      phase_q  <= phase_d;
      strobe_q <= strobe_d;
      if (strobe_d) begin
        sample_q <= y;
      end
    end
  end

  assign sample        = sample_q;
  assign sample_strobe = strobe_q;

endmodule

// File: tb/tb_audio_out.sv
// Directed bench for audio_out: reset, first strobe, filter convergence,
// volume steps, mute decay, tone response, mid-run reset and strobe cadence.
module tb_audio_out;

  localparam longint ClkHz    = 7_159_000;
  localparam longint SampleHz = 48_000;

  logic        clk7_159;
  logic        reset;
  logic        sound_in;
  logic        mute;
  logic [1:0]  volume;
  logic [15:0] sample;
  logic        sample_strobe;

  int checks;
  int errors;
  int edges;

  audio_out dut (
    .clk7_159      (clk7_159),
    .reset         (reset),
    .sound_in      (sound_in),
    .mute          (mute),
    .volume        (volume),
    .sample        (sample),
    .sample_strobe (sample_strobe)
  );

  initial clk7_159 = 1'b0;
  always #5 clk7_159 = ~clk7_159;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk7_159);
    #1;
    edges++;
  endtask

  task automatic wait_strobe(input int bound, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!sample_strobe && n < bound);
  endtask

  // Strobe falls on edge n after reset release when floor(n*SAMPLE/CLK) steps.
  function automatic bit due(input longint n);
    return ((n * SampleHz) / ClkHz) != (((n - 1) * SampleHz) / ClkHz);
  endfunction

  // Filter output after n cycles of constant input x from a cleared accumulator.
  function automatic int model_y(input int n, input int x);
    longint acc = 0;
    for (int i = 0; i < n; i++) acc = acc + x - (acc >> 6);
    return int'(acc >> 6);
  endfunction

  initial begin
    int n;
    int prev;
    int smax;
    int smin;
    int last;
    int nstrobes;
    longint target;

    checks = 0;
    errors = 0;
    edges  = 0;
    reset    = 1'b1;
    sound_in = 1'b0;
    mute     = 1'b0;
    volume   = 2'd0;

    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_sample", 32'(sample), 32'd0);
      check("reset_strobe", 32'(sample_strobe), 32'd0);
    end
    reset = 1'b0;
    edges = 0;

    wait_strobe(1000, n);
    check("first_strobe_edge", n, 150);
    check("first_sample", 32'(sample), 32'(model_y(149, 16383)));

    // Rising toward full scale: non-decreasing at each strobe.
    prev = int'(sample);
    while (edges < 2000) begin
      tick();
      if (sample_strobe) begin
        check("rise_monotonic", 32'(int'(sample) >= prev), 32'd1);
        prev = int'(sample);
      end
    end
    for (int i = 0; i < 3; i++) begin
      wait_strobe(200, n);
      check("converged_16383", 32'(sample), 32'd16383);
    end

    volume = 2'd1;
    repeat (2000) tick();
    wait_strobe(200, n);
    check("volume1_8191", 32'(sample), 32'd8191);

    volume = 2'd2;
    repeat (2000) tick();
    wait_strobe(200, n);
    check("volume2_4095", 32'(sample), 32'd4095);

    volume = 2'd0;
    repeat (2000) tick();
    wait_strobe(200, n);
    check("volume0_16383", 32'(sample), 32'd16383);

    // Mute: monotone decay to zero, held while muted.
    mute = 1'b1;
    prev = int'(sample);
    repeat (2000) begin
      tick();
      if (sample_strobe) begin
        check("mute_monotonic", 32'(int'(sample) <= prev), 32'd1);
        prev = int'(sample);
      end
    end
    for (int i = 0; i < 3; i++) begin
      wait_strobe(200, n);
      check("mute_zero", 32'(sample), 32'd0);
    end
    mute = 1'b0;

    // 1 kHz tone: high (idle) 3580 cycles, low (active) 3579 cycles.
    smax = 0;
    smin = 65535;
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 7159; c++) begin
        sound_in = (c < 3580);
        tick();
        if (sample_strobe) begin
          check("tone_range", 32'(sample <= 16'd16383), 32'd1);
          if (p == 1 && int'(sample) > smax) smax = int'(sample);
          if (p == 1 && int'(sample) < smin) smin = int'(sample);
        end
      end
    end
    check("tone_peak", 32'(smax >= 16000), 32'd1);
    check("tone_trough", 32'(smin <= 383), 32'd1);

    // Reset landing on an edge where a strobe is due.
    sound_in = 1'b0;
    repeat (500) tick();
    check("pre_reset_sample_nonzero", 32'(sample != 16'd0), 32'd1);
    target = longint'(edges) + 1;
    while (!due(target)) target++;
    while (longint'(edges) < target - 1) tick();
    reset = 1'b1;
    tick();
    check("midreset_strobe", 32'(sample_strobe), 32'd0);
    check("midreset_sample", 32'(sample), 32'd0);
    reset = 1'b0;
    edges = 0;
    wait_strobe(1000, n);
    check("post_reset_strobe_edge", n, 150);
    check("post_reset_sample", 32'(sample), 32'(model_y(149, 16383)));

    // Cadence: strobe pattern matches the exact rate, gaps 149/150.
    last = edges;
    nstrobes = 1;
    repeat (15000) begin
      tick();
      check("strobe_schedule", 32'(sample_strobe), 32'(due(longint'(edges))));
      if (sample_strobe) begin
        check("strobe_gap", 32'((edges - last == 149) || (edges - last == 150)), 32'd1);
        last = edges;
        nstrobes++;
      end
    end
    check("strobe_count", nstrobes, 32'((longint'(edges) * SampleHz) / ClkHz));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
